alu_issue_stage: RTL and testbench



---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_decode.sv | 102 ++++++++++
 rtl/alu_issue_stage.sv | 122 ++++++++++++
 tb/tb_alu_issue_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcode, RV32I major-opcode constants and the ID/EX bundle layout
// used by the decode/issue stage.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b1010;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        B_ZERO,
        B_RS2,
        B_IMM_I,
        B_IMM_S,
        B_SHAMT
    } bsel_e;

    typedef struct packed {
        logic [31:0] alu_a;
        logic [31:0] alu_b;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        branch_ne;
        logic [31:0] store_data;
        logic [31:0] pc;
        logic        illegal;
    } idex_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I subset decoder: opcode/funct fields to ALU opcode,
// operand-B source, control flags and illegal indication.
module alu_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output bsel_e      b_sel,
    output logic       keep_rd,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       branch,
    output logic       branch_ne,
    output logic       illegal
);

    always_comb begin
        alu_op    = ALU_ADD;
        b_sel     = B_ZERO;
        keep_rd   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        illegal   = 1'b0;

        case (opcode)
            OP_R: begin
                b_sel     = B_RS2;
                keep_rd   = 1'b1;
                reg_write = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000)      alu_op = ALU_ADD;
                        else if (funct7 == 7'b0100000) alu_op = ALU_SUB;
                        else                           illegal = 1'b1;
                    end
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b101: begin
                        if (funct7 == 7'b0000000) alu_op = ALU_SRL;
                        else                      illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_I: begin
                b_sel     = B_IMM_I;
                keep_rd   = 1'b1;
                reg_write = 1'b1;
                case (funct3)
                    3'b000:  alu_op = ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b101: begin
                        alu_op = ALU_SRL;
                        b_sel  = B_SHAMT;
                        if (funct7 != 7'b0000000) illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LOAD: begin
                b_sel     = B_IMM_I;
                keep_rd   = 1'b1;
                reg_write = 1'b1;
                mem_read  = 1'b1;
                if (funct3 != 3'b010) illegal = 1'b1;
            end
            OP_STORE: begin
                b_sel     = B_IMM_S;
                mem_write = 1'b1;
                if (funct3 != 3'b010) illegal = 1'b1;
            end
            OP_BRANCH: begin
                alu_op    = ALU_SUB;
                b_sel     = B_RS2;
                branch    = 1'b1;
                branch_ne = funct3[0];
                if (funct3[2:1] != 2'b00) illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        // Unsupported encodings still issue as a harmless ADD with zero operand B.
        if (illegal) begin
            alu_op    = ALU_ADD;
            b_sel     = B_ZERO;
            keep_rd   = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            branch    = 1'b0;
            branch_ne = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage: decodes the instruction, builds operand B and holds
// the bundle in a single ID/EX register with valid/ready on both sides.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        branch,
    output logic        branch_ne,
    output logic [31:0] store_data,
    output logic [31:0] pc_out,
    output logic        illegal
);

    logic [3:0] dec_alu_op;
    bsel_e      dec_b_sel;
    logic       dec_keep_rd;
    logic       dec_reg_write, dec_mem_read, dec_mem_write;
    logic       dec_branch, dec_branch_ne, dec_illegal;
    logic [31:0] op_b;
    logic        load;
    logic        unused_rs1_field;

    logic  valid_d,  valid_q;
    idex_t bundle_d, bundle_q;

    alu_decode u_decode (
        .opcode    (instr[6:0]),
        .funct3    (instr[14:12]),
        .funct7    (instr[31:25]),
        .alu_op    (dec_alu_op),
        .b_sel     (dec_b_sel),
        .keep_rd   (dec_keep_rd),
        .reg_write (dec_reg_write),
        .mem_read  (dec_mem_read),
        .mem_write (dec_mem_write),
        .branch    (dec_branch),
        .branch_ne (dec_branch_ne),
        .illegal   (dec_illegal)
    );

    // Register indices arrive already resolved as rs1_data/rs2_data.
    assign unused_rs1_field = ^instr[19:15];

    assign in_ready = ~valid_q | out_ready;
    assign load     = in_valid & in_ready;

    always_comb begin
        case (dec_b_sel)
            B_RS2:   op_b = rs2_data;
            B_IMM_I: op_b = {{20{instr[31]}}, instr[31:20]};
            B_IMM_S: op_b = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            B_SHAMT: op_b = {27'd0, instr[24:20]};
            default: op_b = 32'd0;
        endcase
    end

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d             = 1'b1;
            bundle_d.alu_a      = rs1_data;
            bundle_d.alu_b      = op_b;
            bundle_d.alu_op     = dec_alu_op;
            bundle_d.rd         = dec_keep_rd ? instr[11:7] : 5'd0;
            bundle_d.reg_write  = dec_reg_write;
            bundle_d.mem_read   = dec_mem_read;
            bundle_d.mem_write  = dec_mem_write;
            bundle_d.branch     = dec_branch;
            bundle_d.branch_ne  = dec_branch_ne;
            bundle_d.store_data = rs2_data;
            bundle_d.pc         = pc;
            bundle_d.illegal    = dec_illegal;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid  = valid_q;
    assign alu_a      = bundle_q.alu_a;
    assign alu_b      = bundle_q.alu_b;
    assign alu_op     = bundle_q.alu_op;
    assign rd         = bundle_q.rd;
    assign reg_write  = bundle_q.reg_write;
    assign mem_read   = bundle_q.mem_read;
    assign mem_write  = bundle_q.mem_write;
    assign branch     = bundle_q.branch;
    assign branch_ne  = bundle_q.branch_ne;
    assign store_data = bundle_q.store_data;
    assign pc_out     = bundle_q.pc;
    assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage: expected bundles are queued
// at handshake time and compared while the ID/EX register presents them.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, bne;
        logic [31:0] sd;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data;
    logic [31:0] alu_a, alu_b, store_data, pc_out;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        reg_write, mem_read, mem_write, branch, branch_ne, illegal;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .rd(rd),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .branch_ne(branch_ne), .store_data(store_data),
        .pc_out(pc_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] p);
        exp_t e;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic ok;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        e = '0; e.a = r1; e.sd = r2; e.pc = p; e.op = 4'b0010; ok = 1'b0;
        case (op)
            7'b0110011: begin
                e.b = r2; e.rw = 1'b1; e.rd = ins[11:7]; ok = 1'b1;
                if (f3 == 3'b000 && f7 == 7'h00)      e.op = 4'b0010;
                else if (f3 == 3'b000 && f7 == 7'h20) e.op = 4'b0110;
                else if (f3 == 3'b111)                e.op = 4'b0000;
                else if (f3 == 3'b110)                e.op = 4'b0001;
                else if (f3 == 3'b101 && f7 == 7'h00) e.op = 4'b1010;
                else ok = 1'b0;
            end
            7'b0010011: begin
                e.b = {{20{ins[31]}}, ins[31:20]}; e.rw = 1'b1; e.rd = ins[11:7]; ok = 1'b1;
                if (f3 == 3'b000)      e.op = 4'b0010;
                else if (f3 == 3'b111) e.op = 4'b0000;
                else if (f3 == 3'b110) e.op = 4'b0001;
                else if (f3 == 3'b101 && f7 == 7'h00) begin
                    e.op = 4'b1010; e.b = {27'd0, ins[24:20]};
                end else ok = 1'b0;
            end
            7'b0000011: if (f3 == 3'b010) begin
                ok = 1'b1; e.b = {{20{ins[31]}}, ins[31:20]};
                e.mr = 1'b1; e.rw = 1'b1; e.rd = ins[11:7];
            end
            7'b0100011: if (f3 == 3'b010) begin
                ok = 1'b1; e.b = {{20{ins[31]}}, ins[31:25], ins[11:7]}; e.mw = 1'b1;
            end
            7'b1100011: if (f3 == 3'b000 || f3 == 3'b001) begin
                ok = 1'b1; e.op = 4'b0110; e.b = r2; e.br = 1'b1; e.bne = f3[0];
            end
            default: ;
        endcase
        if (!ok) begin
            e.op = 4'b0010; e.b = '0; e.rd = '0;
            e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.br = 1'b0; e.bne = 1'b0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic check_bundle(input string pfx, input exp_t e);
        chk({pfx, ".alu_a"}, alu_a, e.a);
        chk({pfx, ".alu_b"}, alu_b, e.b);
        chk({pfx, ".alu_op"}, {28'd0, alu_op}, {28'd0, e.op});
        chk({pfx, ".rd"}, {27'd0, rd}, {27'd0, e.rd});
        chk({pfx, ".flags"}, {27'd0, reg_write, mem_read, mem_write, branch, branch_ne},
            {27'd0, e.rw, e.mr, e.mw, e.br, e.bne});
        chk({pfx, ".store_data"}, store_data, e.sd);
        chk({pfx, ".pc_out"}, pc_out, e.pc);
        chk({pfx, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] p,
                         input logic ordy, input logic fl);
        in_valid = v; instr = ins; rs1_data = r1; rs2_data = r2; pc = p;
        out_ready = ordy; flush = fl;
    endtask

    // One clock: predict handshake, update scoreboard, then sample after the edge.
    task automatic step(input string tag);
        logic exp_ready;
        #1;
        exp_ready = (q.size() == 0) || out_ready;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (in_valid && exp_ready) q.push_back(model(instr, rs1_data, rs2_data, pc));
        end
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, (q.size() != 0)});
        if (q.size() != 0) check_bundle(tag, q[0]);
    endtask

    initial begin
        exp_t zero;
        zero = '0;
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2;
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        check_bundle("reset", zero);
        @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 32'h002081B3, 32'd5, 32'd7, 32'h100, 1'b1, 1'b0);
        step("add");
        chk("add.alu_op_const", {28'd0, alu_op}, 32'h2);
        drive(1'b1, 32'h402081B3, 32'd20, 32'd9, 32'h104, 1'b1, 1'b0);
        step("sub");
        drive(1'b1, 32'h0030D213, 32'h80, 32'h55, 32'h108, 1'b1, 1'b0);
        step("srli");
        chk("srli.alu_b_const", alu_b, 32'd3);
        drive(1'b1, 32'hFE20AE23, 32'h1000, 32'hDEADBEEF, 32'h10C, 1'b1, 1'b0);
        step("sw");
        chk("sw.alu_b_const", alu_b, 32'hFFFFFFFC);
        drive(1'b1, 32'h0080A283, 32'h2000, 32'h1, 32'h110, 1'b1, 1'b0);
        step("lw");
        drive(1'b1, 32'h00209063, 32'h33, 32'h34, 32'h114, 1'b1, 1'b0);
        step("bne");
        drive(1'b1, 32'hFFF0F313, 32'hA5A5A5A5, 32'h0, 32'h118, 1'b1, 1'b0);
        step("andi");

        // Backpressure: hold one bundle for three cycles, then refill on release.
        drive(1'b1, 32'h0020E1B3, 32'h0F0, 32'h00F, 32'h200, 1'b0, 1'b0);
        step("or_load");
        drive(1'b1, 32'h002081B3, 32'd11, 32'd12, 32'h204, 1'b0, 1'b0);
        step("hold1");
        step("hold2");
        step("hold3");
        drive(1'b1, 32'h002081B3, 32'd11, 32'd12, 32'h204, 1'b1, 1'b0);
        step("release");
        drive(1'b0, 32'h0, 32'd0, 32'd0, 32'h0, 1'b1, 1'b0);
        step("drain");

        // Flush drops both the held bundle and the incoming one.
        drive(1'b1, 32'h402081B3, 32'd3, 32'd1, 32'h300, 1'b1, 1'b0);
        step("pre_flush");
        drive(1'b1, 32'h002081B3, 32'd4, 32'd4, 32'h304, 1'b1, 1'b1);
        step("flush");
        drive(1'b1, 32'h0000007F, 32'h12345678, 32'h9ABCDEF0, 32'h308, 1'b1, 1'b0);
        step("illegal");
        chk("illegal.alu_b_const", alu_b, 32'd0);

        // Asynchronous reset while a bundle is stalled.
        drive(1'b1, 32'h0030D213, 32'hFFFF0000, 32'h1, 32'h400, 1'b0, 1'b0);
        step("pre_rst");
        step("rst_hold");
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
        check_bundle("async_rst", zero);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd1, 32'd2, 32'h500, 1'b1, 1'b0);
        step("post_rst");
        drive(1'b0, 32'h0, 32'd0, 32'd0, 32'h0, 1'b1, 1'b0);
        step("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
